rpn_wnn_seqnum_arbiter: RTL and testbench

//  Shares the single WNN node sequence-number service between NUM_REQ RPN TX engines (rpn_KIP_TX, rpn_WAN_TX, ...).

---
 rtl/rpn_wnn_seqnum_arbiter_pkg.sv | 21 ++
 rtl/rpn_wnn_seqnum_arbiter_rr_arbiter.sv | 32 +++
 rtl/rpn_wnn_seqnum_arbiter.sv | 156 +++++++++++++++
 tb/tb_rpn_wnn_seqnum_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rpn_wnn_seqnum_arbiter_pkg.sv
// Shared widths, message-type codes and FSM state encodings for the WNN sequence-number arbiter.
// Optional response timeout is enabled with the RPN_WNN_ARB_TIMEOUT_EN macro (see top module).
package rpn_wnn_seqnum_arbiter_pkg;

  localparam int RPN_MSG_TYPE_WIDTH        = 8;
  localparam int AXIS_WAN_TDEST_WIDTH      = 8;
  localparam int WAN_SEQUENCE_NUMBER_WIDTH = 16;

  localparam logic [RPN_MSG_TYPE_WIDTH-1:0] MSG_RDATA = 8'h03;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_RESP = 2'd2;
  localparam logic [1:0] ST_RESP      = 2'd3;

  // Index width that stays legal (>=1) for any requester count.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rpn_wnn_seqnum_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first asserted request after last_grant, wrapping.
module rpn_wnn_seqnum_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int GW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [GW-1:0]      grant_idx,
  output logic               any
);

  int pos;

  // Walk from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    pos       = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      pos = (int'(last_grant) + k) % NUM_REQ;
      if (req[pos]) begin
        grant      = '0;
        grant[pos] = 1'b1;
        grant_idx  = GW'(pos);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rpn_wnn_seqnum_arbiter.sv
// Shares one WNN sequence-number service between NUM_REQ TX engines, one request in flight.
// Define RPN_WNN_ARB_TIMEOUT_EN to re-issue a request after RESP_TIMEOUT silent cycles.
module rpn_wnn_seqnum_arbiter
  import rpn_wnn_seqnum_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int MSG_TYPE_W   = RPN_MSG_TYPE_WIDTH,
  parameter int TDEST_W      = AXIS_WAN_TDEST_WIDTH,
  parameter int SEQ_W        = WAN_SEQUENCE_NUMBER_WIDTH,
  parameter int RESP_TIMEOUT = 256,
  parameter int GW           = idx_w(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_ap_rst,
  input  logic [NUM_REQ-1:0]            req_tvalid,
  output logic [NUM_REQ-1:0]            req_tready,
  input  logic [NUM_REQ*MSG_TYPE_W-1:0] req_tdata,
  input  logic [NUM_REQ*TDEST_W-1:0]    req_tdest,
  output logic [NUM_REQ-1:0]            rsp_tvalid,
  input  logic [NUM_REQ-1:0]            rsp_tready,
  output logic [SEQ_W-1:0]              rsp_tdata,
  output logic [TDEST_W-1:0]            rsp_tdest,
  output logic                          to_WNN_tvalid,
  input  logic                          to_WNN_tready,
  output logic [MSG_TYPE_W-1:0]         to_WNN_tdata,
  output logic [TDEST_W-1:0]            to_WNN_tdest,
  input  logic                          from_WNN_tvalid,
  output logic                          from_WNN_tready,
  input  logic [SEQ_W-1:0]              from_WNN_tdata,
  input  logic [TDEST_W-1:0]            from_WNN_tdest,
  output logic [GW-1:0]                 o_grant_idx,
  output logic                          o_busy,
  output logic                          o_err_tdest,
  output logic                          o_err_timeout,
  output logic [1:0]                    o_state
);

  // Handshakes: a beat transfers on a cycle where tvalid and tready are both high;
  // a source holds tvalid and data stable until that cycle.

  logic [1:0]            state;
  logic [GW-1:0]         grant;
  logic [GW-1:0]         last_grant;
  logic [MSG_TYPE_W-1:0] cap_type;
  logic [TDEST_W-1:0]    cap_dest;
  logic [SEQ_W-1:0]      rsp_seq_q;
  logic [TDEST_W-1:0]    rsp_dest_q;
  logic                  err_tdest_q;
  logic                  err_timeout_q;

  logic [NUM_REQ-1:0]    arb_onehot;
  logic [GW-1:0]         arb_idx;
  logic                  arb_any;

  logic req_hs, to_hs, rsp_match, rsp_drop, rsp_hs, to_fire;

  rpn_wnn_seqnum_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_rr (
    .req        (req_tvalid),
    .last_grant (last_grant),
    .grant      (arb_onehot),
    .grant_idx  (arb_idx),
    .any        (arb_any)
  );

  assign req_hs    = (state == ST_IDLE) && arb_any;
  assign to_hs     = (state == ST_REQ) && to_WNN_tready;
  assign rsp_match = (state == ST_WAIT_RESP) && from_WNN_tvalid && (from_WNN_tdest == cap_dest);
  assign rsp_drop  = (state == ST_WAIT_RESP) && from_WNN_tvalid && (from_WNN_tdest != cap_dest);
  assign rsp_hs    = (state == ST_RESP) && rsp_tready[grant];

`ifdef RPN_WNN_ARB_TIMEOUT_EN
  logic [15:0] to_cnt;

  // A matching response in the expiry cycle takes precedence over the re-issue.
  assign to_fire = (state == ST_WAIT_RESP) && !rsp_match && (to_cnt == 16'(RESP_TIMEOUT - 1));

  always_ff @(posedge i_clk or posedge i_ap_rst) begin
    if (i_ap_rst) begin
      to_cnt        <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      if (to_hs)
        to_cnt <= '0;
      else if (state == ST_WAIT_RESP)
        to_cnt <= to_cnt + 16'd1;
      if (to_fire)
        err_timeout_q <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^RESP_TIMEOUT[15:0];
  assign to_fire            = 1'b0;
  assign err_timeout_q      = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_ap_rst) begin
    if (i_ap_rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      last_grant  <= GW'(NUM_REQ - 1);
      cap_type    <= '0;
      cap_dest    <= '0;
      rsp_seq_q   <= '0;
      rsp_dest_q  <= '0;
      err_tdest_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (req_hs) begin
          cap_type <= req_tdata[int'(arb_idx)*MSG_TYPE_W +: MSG_TYPE_W];
          cap_dest <= req_tdest[int'(arb_idx)*TDEST_W +: TDEST_W];
          grant    <= arb_idx;
          state    <= ST_REQ;
        end
        ST_REQ: if (to_hs) state <= ST_WAIT_RESP;
        ST_WAIT_RESP: begin
          if (rsp_match) begin
            rsp_seq_q  <= from_WNN_tdata;
            rsp_dest_q <= from_WNN_tdest;
            state      <= ST_RESP;
          end else if (to_fire) begin
            state <= ST_REQ;
          end
          if (rsp_drop) err_tdest_q <= 1'b1;
        end
        ST_RESP: if (rsp_hs) begin
          last_grant <= grant;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_tvalid = '0;
    if (state == ST_RESP) rsp_tvalid[grant] = 1'b1;
  end

  assign req_tready      = (state == ST_IDLE) ? arb_onehot : '0;
  assign to_WNN_tvalid   = (state == ST_REQ);
  assign to_WNN_tdata    = cap_type;
  assign to_WNN_tdest    = cap_dest;
  assign from_WNN_tready = (state == ST_WAIT_RESP);
  assign rsp_tdata       = rsp_seq_q;
  assign rsp_tdest       = rsp_dest_q;
  assign o_grant_idx     = grant;
  assign o_busy          = (state != ST_IDLE);
  assign o_err_tdest     = err_tdest_q;
  assign o_err_timeout   = err_timeout_q;
  assign o_state         = state;

endmodule

// File: tb/tb_rpn_wnn_seqnum_arbiter.sv
// Directed bench for the WNN sequence-number arbiter (two requesters, default build).
module tb_rpn_wnn_seqnum_arbiter;
  import rpn_wnn_seqnum_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_tvalid;
  logic [1:0]  req_tready;
  logic [15:0] req_tdata;
  logic [15:0] req_tdest;
  logic [1:0]  rsp_tvalid;
  logic [1:0]  rsp_tready;
  logic [15:0] rsp_tdata;
  logic [7:0]  rsp_tdest;
  logic        to_WNN_tvalid;
  logic        to_WNN_tready;
  logic [7:0]  to_WNN_tdata;
  logic [7:0]  to_WNN_tdest;
  logic        from_WNN_tvalid;
  logic        from_WNN_tready;
  logic [15:0] from_WNN_tdata;
  logic [7:0]  from_WNN_tdest;
  logic [0:0]  grant_idx;
  logic        busy;
  logic        err_tdest;
  logic        err_timeout;
  logic [1:0]  state;

  int tests  = 0;
  int failed = 0;

  localparam logic [7:0] TYPE1 = 8'h11;

  rpn_wnn_seqnum_arbiter dut (
    .i_clk           (clk),
    .i_ap_rst        (rst),
    .req_tvalid      (req_tvalid),
    .req_tready      (req_tready),
    .req_tdata       (req_tdata),
    .req_tdest       (req_tdest),
    .rsp_tvalid      (rsp_tvalid),
    .rsp_tready      (rsp_tready),
    .rsp_tdata       (rsp_tdata),
    .rsp_tdest       (rsp_tdest),
    .to_WNN_tvalid   (to_WNN_tvalid),
    .to_WNN_tready   (to_WNN_tready),
    .to_WNN_tdata    (to_WNN_tdata),
    .to_WNN_tdest    (to_WNN_tdest),
    .from_WNN_tvalid (from_WNN_tvalid),
    .from_WNN_tready (from_WNN_tready),
    .from_WNN_tdata  (from_WNN_tdata),
    .from_WNN_tdest  (from_WNN_tdest),
    .o_grant_idx     (grant_idx),
    .o_busy          (busy),
    .o_err_tdest     (err_tdest),
    .o_err_timeout   (err_timeout),
    .o_state         (state)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction with all readies high; the caller has req_tvalid set.
  task automatic run_txn(input int g, input logic [15:0] seq);
    logic [7:0] dst;
    logic [7:0] typ;
    dst = (g == 0) ? 8'd5 : 8'd7;
    typ = (g == 0) ? MSG_RDATA : TYPE1;
    #1;
    chk("txn_req_tready", 32'(req_tready), 32'(2'b01 << g));
    from_WNN_tvalid = 1'b1;
    from_WNN_tdest  = dst;
    from_WNN_tdata  = seq;
    cyc();
    chk("txn_to_tvalid", 32'(to_WNN_tvalid), 32'd1);
    chk("txn_to_tdata", 32'(to_WNN_tdata), 32'(typ));
    chk("txn_grant_idx", 32'(grant_idx), 32'(g));
    cyc();
    chk("txn_wait", 32'(state), 32'(ST_WAIT_RESP));
    cyc();
    chk("txn_rsp_tvalid", 32'(rsp_tvalid), 32'(2'b01 << g));
    chk("txn_rsp_tdata", 32'(rsp_tdata), 32'(seq));
    from_WNN_tvalid = 1'b0;
    cyc();
    chk("txn_idle", 32'(state), 32'(ST_IDLE));
  endtask

  initial begin
    rst             = 1'b1;
    req_tvalid      = '0;
    req_tdata       = {TYPE1, MSG_RDATA};
    req_tdest       = {8'd7, 8'd5};
    rsp_tready      = 2'b11;
    to_WNN_tready   = 1'b1;
    from_WNN_tvalid = 1'b0;
    from_WNN_tdata  = '0;
    from_WNN_tdest  = '0;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();

    // Reset state
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_to_tvalid", 32'(to_WNN_tvalid), 32'd0);
    chk("rst_rsp_tvalid", 32'(rsp_tvalid), 32'd0);
    chk("rst_from_tready", 32'(from_WNN_tready), 32'd0);
    chk("rst_grant_idx", 32'(grant_idx), 32'd0);
    chk("rst_errs", 32'({err_tdest, err_timeout}), 32'd0);

    // Single request from req0; early WNN response must be back-pressured
    req_tvalid      = 2'b01;
    from_WNN_tvalid = 1'b1;
    from_WNN_tdest  = 8'd5;
    from_WNN_tdata  = 16'd3300;
    #1;
    chk("t1_req_tready", 32'(req_tready), 32'b01);
    cyc();
    req_tvalid = 2'b00;
    chk("t1_req_state", 32'(state), 32'(ST_REQ));
    chk("t1_to_tdata", 32'(to_WNN_tdata), 32'(MSG_RDATA));
    chk("t1_to_tdest", 32'(to_WNN_tdest), 32'd5);
    chk("t1_from_tready_early", 32'(from_WNN_tready), 32'd0);
    chk("t1_req_tready_busy", 32'(req_tready), 32'd0);
    cyc();
    chk("t1_from_tready", 32'(from_WNN_tready), 32'd1);
    chk("t1_to_tvalid_low", 32'(to_WNN_tvalid), 32'd0);
    cyc();
    from_WNN_tvalid = 1'b0;
    chk("t1_rsp_tvalid", 32'(rsp_tvalid), 32'b01);
    chk("t1_rsp_tdata", 32'(rsp_tdata), 32'd3300);
    chk("t1_rsp_tdest", 32'(rsp_tdest), 32'd5);
    cyc();
    chk("t1_idle", 32'(state), 32'(ST_IDLE));
    chk("t1_rsp_gone", 32'(rsp_tvalid), 32'd0);

    // Round robin from a fresh reset with both requesters active
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    req_tvalid = 2'b11;
    run_txn(0, 16'h0101);
    run_txn(1, 16'h0202);
    run_txn(0, 16'h0303);
    run_txn(1, 16'h0404);
    req_tvalid = 2'b00;

    // Mismatched CTDEST is dropped and flagged; matching beat follows intact
    req_tvalid = 2'b01;
    cyc();
    req_tvalid = 2'b00;
    cyc();
    chk("t3_wait", 32'(state), 32'(ST_WAIT_RESP));
    from_WNN_tvalid = 1'b1;
    from_WNN_tdest  = 8'd0;
    from_WNN_tdata  = 16'h1111;
    cyc();
    chk("t3_still_wait", 32'(state), 32'(ST_WAIT_RESP));
    chk("t3_err_tdest", 32'(err_tdest), 32'd1);
    from_WNN_tdest = 8'd5;
    from_WNN_tdata = 16'h0ABC;
    cyc();
    from_WNN_tvalid = 1'b0;
    chk("t3_rsp_tvalid", 32'(rsp_tvalid), 32'b01);
    chk("t3_rsp_tdata", 32'(rsp_tdata), 32'h0ABC);
    cyc();
    chk("t3_err_sticky", 32'(err_tdest), 32'd1);

    // Back-pressure on both the WNN request and the requester response
    to_WNN_tready = 1'b0;
    rsp_tready    = 2'b00;
    req_tvalid    = 2'b10;
    cyc();
    req_tvalid = 2'b00;
    for (int i = 0; i < 10; i++) begin
      chk("t4_to_tvalid_hold", 32'(to_WNN_tvalid), 32'd1);
      chk("t4_to_tdata_hold", 32'({to_WNN_tdata, to_WNN_tdest}), 32'({TYPE1, 8'd7}));
      cyc();
    end
    to_WNN_tready = 1'b1;
    cyc();
    to_WNN_tready   = 1'b0;
    from_WNN_tvalid = 1'b1;
    from_WNN_tdest  = 8'd7;
    from_WNN_tdata  = 16'h2222;
    cyc();
    from_WNN_tvalid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t4_rsp_tvalid_hold", 32'(rsp_tvalid), 32'b10);
      chk("t4_rsp_tdata_hold", 32'(rsp_tdata), 32'h2222);
      chk("t4_no_dup_wnn", 32'({to_WNN_tvalid, from_WNN_tready}), 32'd0);
      cyc();
    end
    rsp_tready = 2'b11;
    cyc();
    chk("t4_idle", 32'(state), 32'(ST_IDLE));
    chk("t4_rsp_gone", 32'(rsp_tvalid), 32'd0);
    to_WNN_tready = 1'b1;

    // Silent WNN: default build keeps waiting, no timeout flag
    req_tvalid = 2'b01;
    cyc();
    req_tvalid = 2'b00;
    repeat (40) cyc();
    chk("t5_still_wait", 32'(state), 32'(ST_WAIT_RESP));
    chk("t5_no_timeout", 32'(err_timeout), 32'd0);
    chk("t5_no_reissue", 32'(to_WNN_tvalid), 32'd0);

    // Asynchronous reset from WAIT_RESP
    #2;
    rst = 1'b1;
    #1;
    chk("t6_state", 32'(state), 32'(ST_IDLE));
    chk("t6_from_tready", 32'(from_WNN_tready), 32'd0);
    chk("t6_err_tdest_clr", 32'(err_tdest), 32'd0);
    chk("t6_outputs", 32'({rsp_tvalid, to_WNN_tvalid, to_WNN_tdata, grant_idx}), 32'd0);
    cyc();
    rst        = 1'b0;
    req_tvalid = 2'b11;
    #1;
    chk("t6_first_grant", 32'(req_tready), 32'b01);
    cyc();
    chk("t6_grant_idx", 32'(grant_idx), 32'd0);
    req_tvalid = 2'b00;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
